grid_io_bank_cfg: RTL and testbench

//  Parametrised I/O tile: NUM_IO embedded SoC pads, each with its own shift-loaded mode/invert config.

---
 rtl/grid_io_bank_cfg.sv | 108 ++++++++++
 tb/tb_grid_io_bank_cfg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_bank_cfg.sv
// NUM_IO SoC pad subtiles configured through a ccff shift chain; a shadow register commits only full loads.
// Optional macro GRID_IO_CFG_PARITY_EN appends an even-parity chain bit and adds the cfg_err output.
module grid_io_bank_cfg #(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              IO_ISOL_N,
  input  logic              ccff_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] right_pin_outpad,
  output logic [NUM_IO-1:0] right_pin_inpad_upper,
  output logic [NUM_IO-1:0] right_pin_inpad_lower,
  output logic              cfg_done
`ifdef GRID_IO_CFG_PARITY_EN
  ,
  output logic              cfg_err
`endif
);

`ifdef GRID_IO_CFG_PARITY_EN
  localparam int CFG_L = 2*NUM_IO + 1;
`else
  localparam int CFG_L = 2*NUM_IO;
`endif
  localparam int CNT_W = $clog2(CFG_L+1);
  localparam int SH_W  = 2*NUM_IO;

  logic [CFG_L-1:0] chain;
  logic [CFG_L-1:0] chain_nxt;
  logic [SH_W-1:0]  shadow;
  logic [CNT_W-1:0] cnt;
  logic             en_q;
  logic             burst_start;
  logic             commit;
  logic             active;

  assign chain_nxt   = {chain[CFG_L-2:0], ccff_head};
  assign burst_start = ccff_en & ~en_q;
  // cnt saturates at CFG_L, so it passes CFG_L-1 exactly once per burst
  assign commit      = ccff_en & en_q & (cnt == CNT_W'(CFG_L-1));

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      chain     <= '0;
      cnt       <= '0;
      en_q      <= 1'b0;
      ccff_tail <= 1'b0;
    end else begin
      en_q <= ccff_en;
      if (ccff_en) begin
        chain     <= chain_nxt;
        ccff_tail <= chain[CFG_L-1];
        if (!en_q)
          cnt <= CNT_W'(1);
        else if (cnt != CNT_W'(CFG_L))
          cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shadow   <= '0;
      cfg_done <= 1'b0;
`ifdef GRID_IO_CFG_PARITY_EN
      cfg_err  <= 1'b0;
`endif
    end else if (burst_start) begin
      cfg_done <= 1'b0;
    end else if (commit) begin
`ifdef GRID_IO_CFG_PARITY_EN
      // even parity over the whole chain: a set XOR marks a corrupted load
      if (~^chain_nxt) begin
        shadow   <= chain_nxt[SH_W-1:0];
        cfg_done <= 1'b1;
        cfg_err  <= 1'b0;
      end else begin
        cfg_err  <= 1'b1;
      end
`else
      shadow   <= chain_nxt[SH_W-1:0];
      cfg_done <= 1'b1;
`endif
    end
  end

  assign active = IO_ISOL_N & cfg_done;

  always_comb begin
    gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = '1;
    gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = '0;
    right_pin_inpad_upper            = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k] = ~(active & shadow[2*k]);
      gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k] = active & shadow[2*k] & (right_pin_outpad[k] ^ shadow[2*k+1]);
      right_pin_inpad_upper[k]            = active & ~shadow[2*k] &
                                            (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k] ^ shadow[2*k+1]);
    end
  end

  assign right_pin_inpad_lower = right_pin_inpad_upper;

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// Bench for grid_io_bank_cfg: directed scenarios plus random bursts against a bit-history reference model.
module tb_grid_io_bank_cfg;
  localparam int NUM_IO = 4;
`ifdef GRID_IO_CFG_PARITY_EN
  localparam int CFG_L = 2*NUM_IO + 1;
`else
  localparam int CFG_L = 2*NUM_IO;
`endif

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              IO_ISOL_N;
  logic              ccff_en;
  logic              ccff_head;
  logic              ccff_tail;
  logic [NUM_IO-1:0] soc_in;
  logic [NUM_IO-1:0] soc_out;
  logic [NUM_IO-1:0] soc_dir;
  logic [NUM_IO-1:0] outpad;
  logic [NUM_IO-1:0] inpad_upper;
  logic [NUM_IO-1:0] inpad_lower;
  logic              cfg_done;
`ifdef GRID_IO_CFG_PARITY_EN
  logic              cfg_err;
`endif

  grid_io_bank_cfg #(.NUM_IO(NUM_IO)) dut (
    .prog_clk                         (prog_clk),
    .pReset                           (pReset),
    .IO_ISOL_N                        (IO_ISOL_N),
    .ccff_en                          (ccff_en),
    .ccff_head                        (ccff_head),
    .ccff_tail                        (ccff_tail),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (soc_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (soc_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (soc_dir),
    .right_pin_outpad                 (outpad),
    .right_pin_inpad_upper            (inpad_upper),
    .right_pin_inpad_lower            (inpad_lower),
    .cfg_done                         (cfg_done)
`ifdef GRID_IO_CFG_PARITY_EN
    ,
    .cfg_err                          (cfg_err)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  int checks;
  int failures;
  bit rand_isol;

  // Reference model: history of shifted bits (newest first) and the committed pad config.
  bit              hist[$];
  int              burst_len;
  bit              prev_en;
  bit              m_done;
  bit              m_err;
  bit              m_tail;
  bit [NUM_IO-1:0] m_mode;
  bit [NUM_IO-1:0] m_inv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    burst_len = 0;
    prev_en   = 1'b0;
    m_done    = 1'b0;
    m_err     = 1'b0;
    m_tail    = 1'b0;
    m_mode    = '0;
    m_inv     = '0;
  endtask

  task automatic model_commit();
    bit par;
    par = 1'b0;
    for (int i = 0; i < CFG_L; i++) par ^= hist[i];
`ifdef GRID_IO_CFG_PARITY_EN
    if (par) begin
      m_err = 1'b1;
      return;
    end
    m_err = 1'b0;
`endif
    m_done = 1'b1;
    for (int k = 0; k < NUM_IO; k++) begin
      m_mode[k] = hist[2*k];
      m_inv[k]  = hist[2*k+1];
    end
  endtask

  task automatic check_outputs(input string tag);
    bit              act;
    bit [NUM_IO-1:0] e_dir;
    bit [NUM_IO-1:0] e_out;
    bit [NUM_IO-1:0] e_in;
    act = IO_ISOL_N && m_done;
    for (int k = 0; k < NUM_IO; k++) begin
      if (act && m_mode[k]) begin
        e_dir[k] = 1'b0;
        e_out[k] = outpad[k] ^ m_inv[k];
        e_in[k]  = 1'b0;
      end else begin
        e_dir[k] = 1'b1;
        e_out[k] = 1'b0;
        e_in[k]  = act && (soc_in[k] ^ m_inv[k]);
      end
    end
    chk({tag, ".dir"},   32'(soc_dir),     32'(e_dir));
    chk({tag, ".out"},   32'(soc_out),     32'(e_out));
    chk({tag, ".in_up"}, 32'(inpad_upper), 32'(e_in));
    chk({tag, ".in_lo"}, 32'(inpad_lower), 32'(e_in));
    chk({tag, ".done"},  32'(cfg_done),    32'(m_done));
    chk({tag, ".tail"},  32'(ccff_tail),   32'(m_tail));
`ifdef GRID_IO_CFG_PARITY_EN
    chk({tag, ".err"},   32'(cfg_err),     32'(m_err));
`endif
  endtask

  // One prog_clk edge: drive at negedge, update the model at posedge, check 1 time unit later.
  task automatic step(input bit en, input bit head);
    @(negedge prog_clk);
    ccff_en   = en;
    ccff_head = head;
    outpad    = NUM_IO'($urandom);
    soc_in    = NUM_IO'($urandom);
    if (rand_isol) IO_ISOL_N = ($urandom_range(0, 5) != 0);
    @(posedge prog_clk);
    if (en) begin
      m_tail = (hist.size() >= CFG_L) ? hist[CFG_L-1] : 1'b0;
      hist.push_front(head);
      if (hist.size() > CFG_L) void'(hist.pop_back());
      if (!prev_en) begin
        burst_len = 1;
        m_done    = 1'b0;
      end else begin
        burst_len++;
      end
      if (burst_len == CFG_L) model_commit();
    end
    prev_en = en;
    #1;
    check_outputs("step");
  endtask

  // Chain image with chain[2k]=mode_k, chain[2k+1]=inv_k and, if present, correct parity on top.
  function automatic logic [CFG_L-1:0] make_vec(input logic [NUM_IO-1:0] mode, input logic [NUM_IO-1:0] inv);
    logic [CFG_L-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      v[2*k]   = mode[k];
      v[2*k+1] = inv[k];
    end
`ifdef GRID_IO_CFG_PARITY_EN
    v[CFG_L-1] = ^v[CFG_L-2:0];
`endif
    return v;
  endfunction

  task automatic shift_vec(input logic [CFG_L-1:0] v);
    for (int i = CFG_L-1; i >= 0; i--) step(1'b1, v[i]);
    step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #1;
    pReset  = 1'b1;
    ccff_en = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(negedge prog_clk);
    pReset = 1'b0;
  endtask

  initial begin
    int n;
    logic [CFG_L-1:0] vec;
    checks    = 0;
    failures  = 0;
    rand_isol = 1'b0;
    pReset    = 1'b1;
    IO_ISOL_N = 1'b1;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    soc_in    = '0;
    outpad    = '0;
    model_reset();
    #2;
    check_outputs("reset0");
    chk("reset0.dir_const", 32'(soc_dir), 32'hF);
    @(negedge prog_clk);
    pReset = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // full load, then fixed pad stimulus with known answers
    shift_vec(make_vec(4'b0101, 4'b0010));
    outpad = 4'hF;
    soc_in = 4'h0;
    #1;
    chk("t2.out",   32'(soc_out),     32'h5);
    chk("t2.dir",   32'(soc_dir),     32'hA);
    chk("t2.inpad", 32'(inpad_upper), 32'h2);
    chk("t2.done",  32'(cfg_done),    32'h1);

    // short burst never commits; the next full burst does
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom));
    step(1'b0, 1'b0);
    chk("t3.done", 32'(cfg_done), 32'h0);
    chk("t3.dir",  32'(soc_dir),  32'hF);
    shift_vec(make_vec(4'b1100, 4'b0110));

    // reload over a committed config: tail streams the old chain out
    shift_vec(make_vec(4'b0011, 4'b1001));

    // global isolation is combinational
    @(negedge prog_clk);
    IO_ISOL_N = 1'b0;
    #1;
    check_outputs("isol");
    chk("isol.dir_const", 32'(soc_dir), 32'hF);
    IO_ISOL_N = 1'b1;
    #1;
    check_outputs("unisol");

    // reset in the middle of a burst
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom));
    do_reset();
    chk("t6.done", 32'(cfg_done), 32'h0);
    step(1'b0, 1'b0);

`ifdef GRID_IO_CFG_PARITY_EN
    vec = make_vec(4'b1010, 4'b0001);
    vec[CFG_L-1] = ~vec[CFG_L-1];
    shift_vec(vec);
    chk("par.err",  32'(cfg_err),  32'h1);
    chk("par.done", 32'(cfg_done), 32'h0);
    chk("par.dir",  32'(soc_dir),  32'hF);
    shift_vec(make_vec(4'b1010, 4'b0001));
    chk("par.err_clr", 32'(cfg_err), 32'h0);
`else
    vec = make_vec(4'b1010, 4'b0001);
    shift_vec(vec);
`endif

    // random bursts of assorted lengths (short, exact, overrun) with random isolation
    rand_isol = 1'b1;
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, CFG_L + 3);
      if ($urandom_range(0, 2) == 0) n = CFG_L;
      for (int j = 0; j < n; j++) step(1'b1, 1'($urandom));
      repeat ($urandom_range(1, 2)) step(1'b0, 1'($urandom));
      if (it == 20) do_reset();
    end
    rand_isol = 1'b0;
    IO_ISOL_N = 1'b1;
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
